// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8-bit asynchronous serial receiver, 1 start bit, 1 stop bit,
// LSB first. An optional even-parity bit sits between data bit 7 and the
// stop bit. Define UART_RX_PARITY_EN to enable it. In the default build
// the frame is 10 bits and parity_err is tied low.
//
// Parameters:
//   clk_freq   system clock frequency in Hz
//   baud       serial bit rate in bits/s
//
// Ports:
//   clk         in   system clock, rising edge, single domain
//   rst         in   asynchronous active-high reset
//   rx          in   serial line, idle high, asynchronous to clk
//   dout_rx     out  [7:0] last received byte, held between frames
//   done_rx     out  one-cycle pulse: good frame received, dout_rx updated
//   frame_err   out  one-cycle pulse: stop bit sampled low
//   parity_err  out  one-cycle pulse: parity mismatch at the stop sample
//   busy        out  high whenever the receiver is not idle
//
// Handshake: done_rx/frame_err/parity_err are single-cycle strobes with no
// back-pressure. The consumer must take dout_rx in the cycle done_rx is
// high, or any time before the next strobe, because dout_rx holds its value.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int clk_freq = 1000000,
    parameter int baud     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dout_rx,
    output logic       done_rx,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    // Bit period and half period, in clk cycles.
    localparam int N    = clk_freq / baud;
    localparam int H    = N / 2;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] N_LAST = CW'(N - 1);
    localparam logic [CW-1:0] H_LAST = CW'(H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_RECOVER
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            rxs_q, rxs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        sync1_d = rx;
        rxs_d   = sync1_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = S_START;
            end
            // Sample mid start bit. A line that is high again there was a glitch.
            S_START: begin
                if (cnt_q == H_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == N_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == N_LAST) begin
                    cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
                    // Even parity: parity bit XOR data must be 0.
                    par_bad_d = rxs_q ^ (^shift_q);
`endif
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == N_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        dout_d  = shift_q;
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) perr_d = 1'b1;
                        else           done_d = 1'b1;
`else
                        done_d = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_RECOVER;
                    end
                end
            end
            // Wait out a break or a stuck-low line before looking for a start bit.
            S_RECOVER: begin
                cnt_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            rxs_q   <= rxs_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign dout_rx   = dout_q;
    assign done_rx   = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx at 1 MHz / 9600 baud
// (N=104, H=52). Frames are driven bit by bit on rx. A negedge monitor
// counts output strobes and checks dout_rx against an expected-byte queue.
// ---------------------------------------------------------------------------
module tb_uart_rx;
    localparam int N = 104;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] dout_rx;
    logic       done_rx;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int last_done_cyc = 0;
    logic [7:0] exp_q[$];

    uart_rx #(.clk_freq(1000000), .baud(9600)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .dout_rx    (dout_rx),
        .done_rx    (done_rx),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (done_rx) begin
                done_cnt++;
                last_done_cyc = cyc;
                check("done_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("dout_on_done", 32'(dout_rx), 32'(exp_q.pop_front()));
                check("done_excl_err", 32'(frame_err | parity_err), 32'd0);
            end
            if (frame_err)  ferr_cnt++;
            if (parity_err) perr_cnt++;
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (N) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par) begin end
`endif
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int t0, d0, f0, p0, lat;

    initial begin
        rx  = 1'b1;
        rst = 1'b1;
        idle(5);
        check("rst_dout",  32'(dout_rx),    32'h00);
        check("rst_done",  32'(done_rx),    32'd0);
        check("rst_ferr",  32'(frame_err),  32'd0);
        check("rst_perr",  32'(parity_err), 32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        rst = 1'b0;
        idle(10);

        // Single frame 0x55 with latency check.
        d0 = done_cnt; f0 = ferr_cnt;
        exp_q.push_back(8'h55);
        t0 = cyc;
        send_frame(8'h55, 1'b0, 1'b1);
        idle(5);
        lat = last_done_cyc - t0;
        check("f55_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("f55_latency_ok", 32'(lat >= 990 && lat <= 992), 32'd1);
        check("f55_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("f55_dout", 32'(dout_rx), 32'h55);
        check("f55_busy", 32'(busy), 32'd0);

        // Back-to-back 0xA3 then 0x0F, no idle gap.
        d0 = done_cnt;
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        send_frame(8'hA3, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b0, 1'b1);
        idle(10);
        check("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
        check("b2b_dout", 32'(dout_rx), 32'h0F);

        // 30-cycle glitch on idle line.
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        rx = 1'b0;
        idle(20);
        check("glitch_busy_high", 32'(busy), 32'd1);
        idle(10);
        rx = 1'b1;
        idle(30);
        check("glitch_busy_low", 32'(busy), 32'd0);
        check("glitch_no_done", 32'(done_cnt - d0), 32'd0);
        check("glitch_no_err", 32'((ferr_cnt - f0) + (perr_cnt - p0)), 32'd0);
        check("glitch_dout", 32'(dout_rx), 32'h0F);

        // 0x3C with a low stop bit, then a 2000-cycle break.
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(2000);
        check("brk_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
        check("brk_no_done", 32'(done_cnt - d0), 32'd0);
        check("brk_busy_held", 32'(busy), 32'd1);
        check("brk_dout", 32'(dout_rx), 32'h0F);
        rx = 1'b1;
        idle(6);
        check("brk_busy_low", 32'(busy), 32'd0);
        idle(200);
        check("brk_single_ferr", 32'(ferr_cnt - f0), 32'd1);

        // Reset during bit 4 of 0xFF, then a clean 0x81.
        d0 = done_cnt; f0 = ferr_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        idle(N / 2);
        check("rst_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        idle(3);
        check("rst_mid_dout", 32'(dout_rx), 32'h00);
        rst = 1'b0;
        idle(5 * N);
        check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_mid_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("rst_mid_idle", 32'(busy), 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b0, 1'b1);
        idle(5);
        check("f81_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("f81_dout", 32'(dout_rx), 32'h81);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1.
        d0 = done_cnt; p0 = perr_cnt;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(5);
        check("par_ok_done", 32'(done_cnt - d0), 32'd1);
        check("par_ok_perr", 32'(perr_cnt - p0), 32'd0);
        check("par_ok_dout", 32'(dout_rx), 32'h07);
        d0 = done_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b0, 1'b1);
        idle(5);
        check("par_bad_perr", 32'(perr_cnt - p0), 32'd1);
        check("par_bad_no_done", 32'(done_cnt - d0), 32'd0);
        check("par_bad_dout", 32'(dout_rx), 32'h07);
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter clk_freq, default 1000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter baud, default 9600, meaning serial bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  system clock; all logic is in this single clock domain, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port dout_rx  output  8  last received data byte.
REQ-007 SHALL have port done_rx  output  1  one-cycle pulse: valid frame received, dout_rx updated.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse: parity mismatch (see Configuration).
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL use bit period N = clk_freq/baud (integer division) and half period H = N/2 (integer division), both in clk cycles.
REQ-012 SHALL pass rx through a 2-flop synchronizer reset to 1; all decisions use the synchronized value rxs.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, RECOVER, with a single cycle counter and a 3-bit bit index.
REQ-014 IDLE: on rxs==0 -> START, clear the counter.
REQ-015 START: after H cycles sample rxs; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: every N cycles sample rxs into a shift register, LSB first; after the 8th sample -> PARITY if enabled, else STOP.
REQ-017 PARITY: after N cycles sample the parity bit -> STOP.
REQ-018 STOP: after N cycles sample rxs; 1 -> dout_rx <= shift register, done_rx pulse (suppressed if parity_err is pulsed in the same cycle), -> IDLE.
REQ-019 STOP sample 0 -> frame_err pulse, dout_rx unchanged, done_rx low, -> RECOVER.
REQ-020 RECOVER: stay until rxs==1, then -> IDLE; a held-low line (break) SHALL NOT generate further frames.
REQ-021 done_rx, frame_err and parity_err SHALL each be high for exactly one clk cycle per event, and never simultaneously with done_rx except as stated in REQ-018.
REQ-022 dout_rx SHALL hold its value between frames and change only in the cycle done_rx or parity_err asserts.
REQ-023 rx activity outside IDLE/RECOVER other than at sample points SHALL be ignored; no mid-bit resynchronization.
REQ-024 A new frame starting right after the stop sample SHALL be received without loss (IDLE is re-entered in one cycle).

Reset
REQ-025 While rst is high: state IDLE, counter and bit index 0, synchronizer flops 1, dout_rx 8'h00, done_rx/frame_err/parity_err/busy 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception restarts at the next falling edge of rxs.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: one even-parity bit is expected between bit 7 and the stop bit; mismatch -> parity_err pulse at the stop sample, dout_rx still updated, done_rx suppressed.
REQ-028 Macro UART_RX_PARITY_EN undefined: PARITY state is unreachable, frame is 10 bits, parity_err is tied to 0.

Verification (clk_freq=1000000, baud=9600, N=104, H=52)
REQ-029 Frame 0x55 (start, 1,0,1,0,1,0,1,0, stop) -> dout_rx=8'h55, one done_rx pulse 52+9*104 cycles (+2 sync) after the falling edge, frame_err=0.
REQ-030 Back-to-back frames 0xA3 then 0x0F with no idle gap -> two done_rx pulses, dout_rx 8'hA3 then 8'h0F.
REQ-031 30-cycle low glitch on idle rx -> no pulses, busy returns to 0 by the cycle after the START sample, dout_rx unchanged.
REQ-032 Frame 0x3C with stop bit low, line held low 2000 cycles then high -> exactly one frame_err, no done_rx, dout_rx unchanged, busy low once line high.
REQ-033 rst pulsed during bit 4 of frame 0xFF, followed by a clean 0x81 -> no pulse for the first frame, dout_rx=8'h81 with done_rx.
REQ-034 With UART_RX_PARITY_EN: 0x07 with parity 1 -> done_rx, dout_rx=8'h07; 0x07 with parity 0 -> parity_err, no done_rx.
